// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_pkg
// Description : Shared defaults and FSM state encoding for the ram16x4
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

  // Default geometry of the attached ram16x4 macro
  localparam int DATA_WIDTH = 4;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  // Controller states: clear sweep, idle/accept, two-cycle read pipe, response
  typedef enum logic [2:0] {
    INIT     = 3'd0,
    IDLE     = 3'd1,
    RD_ISSUE = 3'd2,
    RD_CAPT  = 3'd3,
    RSP      = 3'd4
  } state_t;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram16x4_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram16x4_ctrl
// Description : Request/response front end for a synchronous 16x4 RAM.
//               Clears the RAM after reset, then serves single-cycle writes
//               and three-cycle-latency reads with a held response.
// Revision    : 1.0 - initial release
// ============================================================================
module ram16x4_ctrl #(
  parameter  int DATA_WIDTH = ram_pkg::DATA_WIDTH,
  parameter  int DEPTH      = ram_pkg::DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // request channel
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  // status
  output logic                  init_done,
  // RAM macro side
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  import ram_pkg::*;

  // Last address of the clear sweep; the counter parks here instead of wrapping
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_init_cnt;
  logic [ADDR_WIDTH-1:0] w_init_cnt_nxt;

  logic                  w_ram_we_nxt;
  logic [ADDR_WIDTH-1:0] w_ram_addr_nxt;
  logic [DATA_WIDTH-1:0] w_ram_wdata_nxt;
  logic                  w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
  logic                  w_init_done_nxt;
  logic                  w_req_fire;

  // Requests are only taken while idle; everything else ignores req_*
  assign req_ready  = (r_state == IDLE);
  assign w_req_fire = req_valid && req_ready;

  // State and clear-sweep counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // Registered outputs toward the RAM and the response channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      init_done <= 1'b0;
    end else begin
      ram_we    <= w_ram_we_nxt;
      ram_addr  <= w_ram_addr_nxt;
      ram_wdata <= w_ram_wdata_nxt;
      rsp_valid <= w_rsp_valid_nxt;
      rsp_rdata <= w_rsp_rdata_nxt;
      init_done <= w_init_done_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_init_cnt_nxt  = r_init_cnt;
    w_ram_we_nxt    = 1'b0;
    w_ram_addr_nxt  = ram_addr;
    w_ram_wdata_nxt = ram_wdata;
    w_rsp_valid_nxt = rsp_valid;
    w_rsp_rdata_nxt = rsp_rdata;
    w_init_done_nxt = init_done;

    case (r_state)
      INIT: begin
        // One zero-write per cycle, addresses 0..DEPTH-1, exactly once
        w_ram_we_nxt    = 1'b1;
        w_ram_addr_nxt  = r_init_cnt;
        w_ram_wdata_nxt = '0;
        if (r_init_cnt == c_last_addr) begin
          w_state_nxt     = IDLE;
          w_init_done_nxt = 1'b1;
        end else begin
          w_init_cnt_nxt = r_init_cnt + 1'b1;
        end
      end

      IDLE: begin
        if (w_req_fire) begin
          w_ram_addr_nxt = req_addr;
          if (req_we) begin
            // Writes complete in the RAM next cycle; stay idle for back-to-back
            w_ram_we_nxt    = 1'b1;
            w_ram_wdata_nxt = req_wdata;
          end else begin
            w_state_nxt = RD_ISSUE;
          end
        end
      end

      RD_ISSUE: begin
        // Address is on the RAM this cycle; data appears the next one
        w_state_nxt = RD_CAPT;
      end

      RD_CAPT: begin
        w_rsp_rdata_nxt = ram_rdata;
        w_rsp_valid_nxt = 1'b1;
        w_state_nxt     = RSP;
      end

      RSP: begin
        // Response holds until the consumer takes it
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end

      default: begin
        w_state_nxt = INIT;
      end
    endcase
  end

endmodule : ram16x4_ctrl
`default_nettype wire

// File: tb/tb_ram16x4_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram16x4_ctrl
// Description : Self-checking bench for ram16x4_ctrl paired with a
//               behavioural ram16x4 and a word-array reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram16x4_ctrl;

  localparam int DW    = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] ref_mem [DEPTH];

  ram16x4_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural ram16x4: synchronous write, registered read; preloaded with
  // non-zero junk so the clear sweep has something to erase
  logic [DW-1:0] ram_mem [DEPTH];
  logic          preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= DW'(i) ^ 4'hA;
      preloaded <= 1'b1;
    end else if (ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
    end else begin
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Assert reset mid-cycle, check the forced values, release and follow the sweep
  task automatic reset_and_sweep(input bit req_during_init);
    rst_n = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_ram_we",    ram_we,    0);
    chk("rst_ram_addr",  ram_addr,  0);
    chk("rst_ram_wdata", ram_wdata, 0);
    if (req_during_init) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd9; req_wdata = 4'hF;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      chk("init_ram_we",    ram_we,    1);
      chk("init_ram_addr",  ram_addr,  32'(i));
      chk("init_ram_wdata", ram_wdata, 0);
      chk("init_req_ready", req_ready, (i == DEPTH - 1) ? 1 : 0);
      chk("init_done_flag", init_done, (i == DEPTH - 1) ? 1 : 0);
      chk("init_rsp_valid", rsp_valid, 0);
      if (i == DEPTH - 1) req_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("init_no_wrap_we", ram_we,    0);
    chk("init_done_hold",  init_done, 1);
    chk("idle_req_ready",  req_ready, 1);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk("wr_ready", req_ready, 1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    ref_mem[a] = d;
    chk("wr_ram_we",    ram_we,    1);
    chk("wr_ram_addr",  ram_addr,  32'(a));
    chk("wr_ram_wdata", ram_wdata, 32'(d));
    chk("wr_stay_idle", req_ready, 1);
    chk("wr_no_rsp",    rsp_valid, 0);
  endtask

  // Issue a read, measure latency, hold the response, optionally poke junk requests
  task automatic do_read(input logic [AW-1:0] a, input int hold, input bit junk, input bit early);
    logic [DW-1:0] exp;
    int lat;
    chk("rd_ready", req_ready, 1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (early) rsp_ready = 1'b1;
    chk("rd_issue_we",    ram_we,    0);
    chk("rd_issue_addr",  ram_addr,  32'(a));
    chk("rd_busy_ready",  req_ready, 0);
    chk("rd_issue_valid", rsp_valid, 0);
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rd_latency", lat, 3);
    exp = ref_mem[a];
    chk("rd_data", rsp_rdata, 32'(exp));
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      if (junk) begin
        req_valid = 1'b1; req_we = 1'b1;
        req_addr = AW'($urandom_range(0, DEPTH - 1)); req_wdata = DW'($urandom);
      end
      @(posedge clk); #1;
      chk("hold_valid",  rsp_valid, 1);
      chk("hold_data",   rsp_rdata, 32'(exp));
      chk("hold_ready0", req_ready, 0);
      chk("hold_no_we",  ram_we,    0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_done_valid", rsp_valid, 0);
    chk("rsp_done_idle",  req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    int op;

    // Hold reset a few cycles, then clear sweep with a request pending throughout
    repeat (3) @(posedge clk);
    #1;
    reset_and_sweep(1'b1);

    // Cleared memory reads zero, including the address targeted during INIT
    do_read(4'd7, 0, 1'b0, 1'b0);
    do_read(4'd9, 0, 1'b0, 1'b0);

    // Write then immediate read of the same word
    do_write(4'd3, 4'hA);
    do_read(4'd3, 0, 1'b0, 1'b0);

    // Back-to-back writes, then read both
    do_write(4'd5,  4'hC);
    do_write(4'd15, 4'h3);
    do_read(4'd5,  0, 1'b0, 1'b0);
    do_read(4'd15, 0, 1'b0, 1'b0);

    // Stalled response with junk requests, and an early rsp_ready
    do_read(4'd5, 5, 1'b1, 1'b0);
    do_read(4'd3, 0, 1'b0, 1'b1);

    // Randomized mix of writes, reads and idle cycles
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 3));
      ra = AW'($urandom_range(0, DEPTH - 1));
      rd = DW'($urandom);
      if (op <= 1) begin
        do_write(ra, rd);
      end else if (op == 2) begin
        do_read(ra, int'($urandom_range(0, 2)), 1'(($urandom % 2)), 1'b0);
      end else begin
        @(posedge clk); #1;
        chk("idle_no_we", ram_we, 0);
      end
    end

    // Reset during RD_CAPT drops the read and re-clears
    do_write(4'd5, 4'hC);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("capt_valid_low", rsp_valid, 0);
    reset_and_sweep(1'b0);
    do_read(4'd5, 0, 1'b0, 1'b0);

    // Reset while a response is being held drops it immediately
    do_write(4'd6, 4'h9);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd6;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rsp_pre_reset_valid", rsp_valid, 1);
    chk("rsp_pre_reset_data",  rsp_rdata, 32'h9);
    reset_and_sweep(1'b0);
    do_read(4'd6, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ram16x4_ctrl
`default_nettype wire

// File: doc/ram16x4_ctrl.md
RAM16X4_CTRL -- requirements
Module: ram16x4_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, 4, word width.
REQ-002 Parameter: DEPTH, 16, number of words (power of two); ADDR_WIDTH = $clog2(DEPTH).
REQ-003 Port: clk  input  1  single clock, all state rises on posedge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: req_valid  input  1  request present.
REQ-006 Port: req_ready  output  1  request accepted when valid&ready at posedge.
REQ-007 Port: req_we  input  1  1 = write, 0 = read.
REQ-008 Port: req_addr  input  ADDR_WIDTH  word address.
REQ-009 Port: req_wdata  input  DATA_WIDTH  write data.
REQ-010 Port: rsp_valid  output  1  read data present.
REQ-011 Port: rsp_ready  input  1  consumer takes response when valid&ready at posedge.
REQ-012 Port: rsp_rdata  output  DATA_WIDTH  read data.
REQ-013 Port: init_done  output  1  memory clear complete.
REQ-014 Port: ram_we / ram_addr / ram_wdata  output  1 / ADDR_WIDTH / DATA_WIDTH  drive ram16x4 write_enable/addr/data_in; all registered.
REQ-015 Port: ram_rdata  input  DATA_WIDTH  from ram16x4 data_out; valid the cycle after ram_addr is presented with ram_we=0.

Function
REQ-016 FSM states SHALL be INIT, IDLE, RD_ISSUE, RD_CAPT, RSP.
REQ-017 INIT: ram_we=1, ram_wdata=0, ram_addr steps 0..DEPTH-1 one per cycle, first write the first posedge after rst_n release; after address DEPTH-1 -> IDLE, init_done=1 and stays 1 until reset.
REQ-018 req_ready SHALL be 1 only in IDLE (never in INIT, RD_*, RSP).
REQ-019 Write accepted at cycle N: ram_we=1, ram_addr/ram_wdata = request in cycle N+1, ram_we=0 afterwards unless another write accepted; FSM stays IDLE; no response generated.
REQ-020 Back-to-back writes SHALL sustain one per cycle.
REQ-021 Read accepted at cycle N: RD_ISSUE at N+1 (ram_we=0, ram_addr=req_addr); RD_CAPT at N+2 registers ram_rdata into rsp_rdata; RSP at N+3 with rsp_valid=1.
REQ-022 In RSP, rsp_valid and rsp_rdata SHALL hold stable until rsp_ready=1; then -> IDLE next cycle with rsp_valid=0.
REQ-023 Write at N followed by read of same address at N+1 SHALL return the newly written data.
REQ-024 rsp_ready while rsp_valid=0 SHALL be ignored; req_* outside IDLE SHALL be ignored.
REQ-025 INIT address counter SHALL not wrap into a second sweep; exactly DEPTH writes.
REQ-026 Read accept-to-rsp_valid latency SHALL be exactly 3 cycles; minimum read-to-read spacing 4 cycles.

Reset
REQ-027 rst_n low SHALL immediately force: state INIT, req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, ram_we=0, ram_addr=0, ram_wdata=0, init counter=0.
REQ-028 Reset mid-read or mid-RSP SHALL drop the pending response and restart the full clear sweep.

Structure
REQ-029 ram_pkg SHALL hold DATA_WIDTH, DEPTH, ADDR_WIDTH defaults and the FSM state enum.
REQ-030 No sub-module; init counter and FSM inline; ram16x4 instantiated by the parent, not inside this block.

Verification (bench pairs block with ram16x4)
REQ-031 Release rst_n -> ram_we high 16 consecutive cycles, addr 0..15, data 0; init_done=1 after; read addr 7 -> rsp_rdata=0x0.
REQ-032 Write 0xA@3, then read 3 next cycle -> rsp_valid exactly 3 cycles after read accept, rsp_rdata=0xA.
REQ-033 Writes 0xC@5, 0x3@15 back-to-back (req_ready stays 1) -> reads return 0xC, 0x3.
REQ-034 Read 5 with rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata=0xC stable, req_ready=0; rsp_ready=1 -> IDLE next cycle.
REQ-035 rst_n pulsed low in RD_CAPT -> rsp_valid=0 immediately, 16-cycle re-clear, then read 5 -> 0x0.
REQ-036 req_valid=1 during INIT -> no acceptance, no extra ram_we pulses.
